// File: rtl/decoder38_pulse.sv
// decoder38_pulse: FIFO-buffered 3-to-8 decoder driving one active-low line for HOLD_CYCLES cycles
module decoder38_pulse #(
  parameter int HOLD_CYCLES = 4,
  parameter int DEPTH = 4
) (
  input  logic                     iClk,
  input  logic                     iRst_n,
  input  logic [2:0]               iData,
  input  logic                     iValid,
  output logic                     oReady,
  input  logic                     iEI,
  output logic [7:0]               oData,
  output logic                     oEO,
  output logic [$clog2(DEPTH):0]   oCount
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0] HOLD_M1 = 8'(HOLD_CYCLES - 1);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic [7:0] cnt_q, cnt_d, data_q, data_d;
  logic eo_q, eo_d;
  logic [2:0] mem_q [DEPTH];
  logic push, pop;
  assign oReady = count_q != (AW+1)'(DEPTH);
  assign push = iValid && oReady;
  assign pop = !iEI && count_q != '0 && (state_q == IDLE || cnt_q == '0);
  assign oData = data_q;
  assign oEO = eo_q;
  assign oCount = count_q;
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    state_d = IDLE;
    data_d = 8'hFF;
    eo_d = 1'b0;
    cnt_d = '0;
    if (pop) begin
      state_d = HOLD;
      data_d = ~(8'd1 << mem_q[rd_ptr_q]);
      eo_d = 1'b1;
      cnt_d = HOLD_M1;
    end else if (!iEI && state_q == HOLD && cnt_q != '0) begin
      state_d = HOLD;
      data_d = data_q;
      eo_d = 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      cnt_q <= '0;
      data_q <= 8'hFF;
      eo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      eo_q <= eo_d;
    end
  end
  always_ff @(posedge iClk) begin
    if (push) mem_q[wr_ptr_q] <= iData;
  end
endmodule

// File: doc/decoder38_pulse.md
Name: decoder38_pulse

Overview:
- Buffered 3-to-8 line decoder with active-low outputs; the inverse of the team's 8-3 priority encoder.
- Accepts 3-bit codes through a valid/ready handshake and queues them in a small FIFO.
- Drives each queued code as a single active-low line for a programmable number of cycles.
- Used to drive scanned select lines (digit/row strobes) whose consumers expect active-low one-hot inputs.

Parameters:
- HOLD_CYCLES, 4, cycles each decoded line is held low (legal range 1..255).
- DEPTH, 4, FIFO depth in entries (power of 2, >=2).

Ports:
- iClk  input  1  clock, rising edge.
- iRst_n  input  1  asynchronous reset, active low.
- iData  input  3  code to decode (0..7).
- iValid  input  1  iData valid, active high.
- oReady  output  1  FIFO can accept; oReady = !full (combinational from registered count).
- iEI  input  1  enable, active low; high = outputs disabled and draining paused.
- oData  output  8  decoded lines, active low, at most one bit low, registered.
- oEO  output  1  high while a line is being driven (HOLD state), registered.
- oCount  output  $clog2(DEPTH)+1  FIFO occupancy, registered.

Behaviour:
- Reset (async assert, sync release): FIFO empty, oCount=0, oData=8'hFF, oEO=0, state IDLE, hold counter 0. oReady=1.
- Push: on a rising edge with iValid&&oReady, write iData at the write pointer; pointer wraps modulo DEPTH. iValid while !oReady is ignored; the producer holds data.
- Push is accepted regardless of iEI.
- States: IDLE, HOLD.
- IDLE: at an edge where iEI==0 and oCount!=0, pop the head code c. oData <= ~(8'b1<<c), oEO <= 1, counter <= HOLD_CYCLES-1, go to HOLD. Otherwise oData=FF, oEO=0.
- No bypass: a code pushed at edge k reaches oData at edge k+1 at the earliest, i.e. one cycle of latency.
- HOLD, iEI==0, counter!=0: decrement the counter; oData unchanged.
- HOLD, iEI==0, counter==0, oCount!=0: pop the next code back-to-back, with no FF gap, and reload the counter. oEO stays 1.
- HOLD, iEI==0, counter==0, FIFO empty: oData <= FF, oEO <= 0, go to IDLE.
- Net result: each line is low for exactly HOLD_CYCLES cycles.
- iEI high in any state: at the next edge oData <= FF, oEO <= 0, the counter clears and the state goes to IDLE. The code in progress is dropped, not re-queued. FIFO contents are retained.
- Simultaneous push and pop: both occur and oCount is unchanged. When full, a pop at edge k raises oReady after edge k; a push is possible at edge k+1.
- iData values are always 0..7, so no illegal codes exist.
- Async reset mid-hold forces the reset values immediately and the FIFO contents are lost.

Test Plan:
- Reset: assert iRst_n=0 mid-clock -> oData=8'hFF, oEO=0, oCount=0, oReady=1 immediately without a clock edge.
- Single code, HOLD_CYCLES=4, iEI=0: push 3'd5 at edge 0 -> from edge 1 oData=8'b1101_1111, oEO=1 for exactly 4 cycles; at edge 5 oData=FF, oEO=0.
- Back-to-back: push 0,7,2 on consecutive edges -> oData = FE for 4 cycles, then 7F for 4 cycles, then FB for 4 cycles, with no FF cycle between them; oEO continuously 1 for 12 cycles.
- Full FIFO, DEPTH=4, iEI=1: push 1,2,3,4 -> oCount=4, oReady=0; a fifth push is ignored. Drop iEI -> drain order 1,2,3,4; oReady=1 the cycle after the first pop.
- Disable mid-hold: code 6 held for 2 cycles, raise iEI -> next edge oData=FF, oEO=0. Queued code 1 waits; on lowering iEI it is driven (FD) and code 6 is not replayed.
- Simultaneous push/pop: with oCount=2 at a pop edge, push in the same edge -> oCount stays 2, and FIFO order is preserved across pointer wrap over 3 full wraps.
